// File: rtl/lc3b_mem_access_ctrl.sv
// LC-3b data-memory access sequencer: one LDR/LDB/STR/STB per start.
// Drives the memory handshake, lane steering and the load writeback.
module lc3b_mem_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        is_store,
   input  logic        is_byte,
   input  logic [15:0] addr,
   input  logic [15:0] store_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [15:0] mem_address,
   output logic [1:0]  mem_byte_enable,
   output logic [15:0] mem_wdata,
   input  logic        mem_resp,
   input  logic [15:0] mem_rdata,
   output logic        load_regfile,
   output logic [15:0] regfile_data
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WB, FIN} state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          store_q, store_d;
   logic          byte_q, byte_d;
   logic          hi_q, hi_d;
   logic          busy_d, done_d, err_d, rd_d, wr_d, ld_d;
   logic [1:0]    be_d;
   logic [15:0]   addr_d, wdata_d, rf_d;
   logic          expired;

   assign expired = (TIMEOUT_CYCLES != 0) &&
                    (int'(cnt) == TIMEOUT_CYCLES - 1);

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      store_d = store_q;
      byte_d  = byte_q;
      hi_d    = hi_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      ld_d    = 1'b0;
      be_d    = 2'b00;
      addr_d  = mem_address;
      wdata_d = mem_wdata;
      rf_d    = regfile_data;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (!is_byte && addr[0]) begin
                  state_d = FIN;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d = REQ;
                  cnt_d   = '0;
                  store_d = is_store;
                  byte_d  = is_byte;
                  hi_d    = addr[0];
                  addr_d  = {addr[15:1], 1'b0};
                  be_d    = is_byte ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
                  wdata_d = is_byte ? {2{store_data[7:0]}} : store_data;
                  rd_d    = !is_store;
                  wr_d    = is_store;
               end
            end
         end
         REQ: begin
            if (mem_resp) begin
               done_d = 1'b1;
               if (store_q) begin
                  state_d = FIN;
               end else begin
                  state_d = WB;
                  ld_d    = 1'b1;
                  if (byte_q)
                     rf_d = {8'h00, hi_q ? mem_rdata[15:8] : mem_rdata[7:0]};
                  else
                     rf_d = mem_rdata;
               end
            end else if (expired) begin
               // Abandon the access; the memory side sees the request drop.
               state_d = FIN;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else begin
               if (TIMEOUT_CYCLES != 0)
                  cnt_d = cnt + 1'b1;
               rd_d = mem_read;
               wr_d = mem_write;
               be_d = mem_byte_enable;
            end
         end
         WB:      state_d = IDLE;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state           <= IDLE;
         cnt             <= '0;
         store_q         <= 1'b0;
         byte_q          <= 1'b0;
         hi_q            <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         load_regfile    <= 1'b0;
         mem_byte_enable <= 2'b00;
         mem_address     <= 16'h0000;
         mem_wdata       <= 16'h0000;
         regfile_data    <= 16'h0000;
      end else begin
         state           <= state_d;
         cnt             <= cnt_d;
         store_q         <= store_d;
         byte_q          <= byte_d;
         hi_q            <= hi_d;
         busy            <= busy_d;
         done            <= done_d;
         err             <= err_d;
         mem_read        <= rd_d;
         mem_write       <= wr_d;
         load_regfile    <= ld_d;
         mem_byte_enable <= be_d;
         mem_address     <= addr_d;
         mem_wdata       <= wdata_d;
         regfile_data    <= rf_d;
      end
   end

endmodule

// File: tb/tb_lc3b_mem_access_ctrl.sv
// Directed bench for lc3b_mem_access_ctrl with a 4-cycle request timeout.
// Each step advances one rising edge and samples 1ns later.
module tb_lc3b_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start, is_store, is_byte;
   logic [15:0] addr, store_data;
   logic        busy, done, err, mem_read, mem_write;
   logic [15:0] mem_address, mem_wdata;
   logic [1:0]  mem_byte_enable;
   logic        mem_resp;
   logic [15:0] mem_rdata;
   logic        load_regfile;
   logic [15:0] regfile_data;

   int total = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lc3b_mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .is_store(is_store), .is_byte(is_byte), .addr(addr),
      .store_data(store_data), .busy(busy), .done(done), .err(err),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_byte_enable(mem_byte_enable),
      .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .load_regfile(load_regfile), .regfile_data(regfile_data)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic st, input logic by,
                      input logic [15:0] a, input logic [15:0] sd);
      start = 1'b1; is_store = st; is_byte = by;
      addr = a; store_data = sd;
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; is_store = 1'b0; is_byte = 1'b0;
      addr = '0; store_data = '0; mem_resp = 1'b0; mem_rdata = '0;
      step(); step();
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_done", 16'(done), 16'h0);
      chk("rst_err", 16'(err), 16'h0);
      chk("rst_rd", 16'(mem_read), 16'h0);
      chk("rst_wr", 16'(mem_write), 16'h0);
      chk("rst_ld", 16'(load_regfile), 16'h0);
      chk("rst_be", 16'(mem_byte_enable), 16'h0);
      chk("rst_addr", mem_address, 16'h0);
      chk("rst_wdata", mem_wdata, 16'h0);
      chk("rst_rf", regfile_data, 16'h0);
      reset_n = 1'b1;
      step();

      // 1: LDB high lane, resp in third request cycle
      req(1'b0, 1'b1, 16'h3001, 16'h0);
      step();
      start = 1'b0;
      chk("t1_rd", 16'(mem_read), 16'h1);
      chk("t1_wr", 16'(mem_write), 16'h0);
      chk("t1_be", 16'(mem_byte_enable), 16'h2);
      chk("t1_addr", mem_address, 16'h3000);
      chk("t1_busy", 16'(busy), 16'h1);
      step();
      chk("t1_rd2", 16'(mem_read), 16'h1);
      step();
      chk("t1_rd3", 16'(mem_read), 16'h1);
      chk("t1_nodone", 16'(done), 16'h0);
      mem_resp = 1'b1; mem_rdata = 16'hA55A;
      step();
      mem_resp = 1'b0; mem_rdata = 16'h0;
      chk("t1_done", 16'(done), 16'h1);
      chk("t1_ld", 16'(load_regfile), 16'h1);
      chk("t1_rf", regfile_data, 16'h00A5);
      chk("t1_rd_off", 16'(mem_read), 16'h0);
      chk("t1_err", 16'(err), 16'h0);
      step();
      chk("t1_done_1cy", 16'(done), 16'h0);
      chk("t1_ld_1cy", 16'(load_regfile), 16'h0);
      chk("t1_idle", 16'(busy), 16'h0);
      chk("t1_rf_hold", regfile_data, 16'h00A5);

      // 2: STB low lane with replication
      req(1'b1, 1'b1, 16'h2000, 16'h12C3);
      step();
      start = 1'b0;
      chk("t2_wr", 16'(mem_write), 16'h1);
      chk("t2_rd", 16'(mem_read), 16'h0);
      chk("t2_be", 16'(mem_byte_enable), 16'h1);
      chk("t2_wdata", mem_wdata, 16'hC3C3);
      chk("t2_addr", mem_address, 16'h2000);
      mem_resp = 1'b1;
      step();
      mem_resp = 1'b0;
      chk("t2_done", 16'(done), 16'h1);
      chk("t2_ld", 16'(load_regfile), 16'h0);
      chk("t2_wr_off", 16'(mem_write), 16'h0);
      step();
      chk("t2_done_1cy", 16'(done), 16'h0);
      chk("t2_idle", 16'(busy), 16'h0);

      // 3: misaligned LDR
      req(1'b0, 1'b0, 16'h1235, 16'h0);
      step();
      start = 1'b0;
      chk("t3_done", 16'(done), 16'h1);
      chk("t3_err", 16'(err), 16'h1);
      chk("t3_rd", 16'(mem_read), 16'h0);
      chk("t3_wr", 16'(mem_write), 16'h0);
      step();
      chk("t3_done_1cy", 16'(done), 16'h0);
      chk("t3_err_1cy", 16'(err), 16'h0);
      chk("t3_idle", 16'(busy), 16'h0);

      // 4: STR timeout after 4 request cycles
      req(1'b1, 1'b0, 16'h0100, 16'h5678);
      step();
      start = 1'b0;
      chk("t4_wdata", mem_wdata, 16'h5678);
      chk("t4_be", 16'(mem_byte_enable), 16'h3);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t4_wr%0d", i), 16'(mem_write), 16'h1);
         chk($sformatf("t4_nodone%0d", i), 16'(done), 16'h0);
         step();
      end
      chk("t4_done", 16'(done), 16'h1);
      chk("t4_err", 16'(err), 16'h1);
      chk("t4_wr_off", 16'(mem_write), 16'h0);
      mem_resp = 1'b1;
      step();
      mem_resp = 1'b0;
      chk("t4_late_done", 16'(done), 16'h0);
      chk("t4_idle", 16'(busy), 16'h0);
      step();
      chk("t4_late_done2", 16'(done), 16'h0);
      chk("t4_wr_idle", 16'(mem_write), 16'h0);
      chk("t4_busy_idle", 16'(busy), 16'h0);

      // 5: start while busy ignored, reset mid-request
      req(1'b0, 1'b0, 16'h0200, 16'h0);
      step();
      req(1'b1, 1'b1, 16'h0301, 16'hFFFF);
      step();
      start = 1'b0;
      chk("t5_addr", mem_address, 16'h0200);
      chk("t5_rd", 16'(mem_read), 16'h1);
      chk("t5_wr", 16'(mem_write), 16'h0);
      reset_n = 1'b0;
      step();
      chk("t5_busy", 16'(busy), 16'h0);
      chk("t5_rd_rst", 16'(mem_read), 16'h0);
      chk("t5_done_rst", 16'(done), 16'h0);
      chk("t5_rf_rst", regfile_data, 16'h0);
      chk("t5_addr_rst", mem_address, 16'h0);
      chk("t5_be_rst", 16'(mem_byte_enable), 16'h0);
      reset_n = 1'b1;
      step();
      chk("t5_done_post", 16'(done), 16'h0);
      chk("t5_busy_post", 16'(busy), 16'h0);
      req(1'b0, 1'b0, 16'h0202, 16'h0);
      step();
      start = 1'b0;
      chk("t5_rd2", 16'(mem_read), 16'h1);
      chk("t5_addr2", mem_address, 16'h0202);
      mem_resp = 1'b1; mem_rdata = 16'h1357;
      step();
      mem_resp = 1'b0;
      chk("t5_rf2", regfile_data, 16'h1357);
      chk("t5_ld2", 16'(load_regfile), 16'h1);
      step();

      // 6: back-to-back LDR then STB at resp+2
      req(1'b0, 1'b0, 16'h4000, 16'h0);
      step();
      start = 1'b0;
      mem_resp = 1'b1; mem_rdata = 16'hBEEF;
      step();
      mem_resp = 1'b0;
      chk("t6_rf", regfile_data, 16'hBEEF);
      chk("t6_done", 16'(done), 16'h1);
      step();
      chk("t6_idle", 16'(busy), 16'h0);
      req(1'b1, 1'b1, 16'h4003, 16'h00AB);
      step();
      start = 1'b0;
      chk("t6_be", 16'(mem_byte_enable), 16'h2);
      chk("t6_wr", 16'(mem_write), 16'h1);
      chk("t6_wdata", mem_wdata, 16'hABAB);
      chk("t6_addr", mem_address, 16'h4002);
      mem_resp = 1'b1;
      step();
      mem_resp = 1'b0;
      chk("t6_done2", 16'(done), 16'h1);
      chk("t6_ld2", 16'(load_regfile), 16'h0);
      step();

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
